// File: rtl/ahb_lite_slave_fe.sv
// AHB-Lite slave front-end: turns single AHB transfers into held req/ack requests for the SDRAM core.
// Optional feature macro AHB_SLV_ERR_RESP_EN: two-cycle ERROR response for bad HSIZE or misaligned accesses.
module ahb_lite_slave_fe #(
    parameter int ADDR_W = 25
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

`ifdef AHB_SLV_ERR_RESP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       addr_phase;
    logic       start_xfer;
    logic [3:0] be_dec;
    logic       ready_nxt;
    logic       req_nxt;

    // Address bits above the decoded window and the SEQ/NONSEQ distinction carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:ADDR_W], HTRANS[0]};

    // Write data is only valid in the data phase, so it is passed straight through, not captured.
    assign mem_wdata = HWDATA;

    assign addr_phase = HSEL & HTRANS[1] & HREADY & (state == ST_IDLE);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        be_dec = 4'b1111;
        case (HSIZE)
            3'd0:    be_dec = 4'b0001 << HADDR[1:0];
            3'd1:    be_dec = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase
    end

`ifdef AHB_SLV_ERR_RESP_EN
    logic bad_xfer;
    logic resp_nxt;

    always_comb begin
        bad_xfer = 1'b0;
        case (HSIZE)
            3'd0:    bad_xfer = 1'b0;
            3'd1:    bad_xfer = HADDR[0];
            3'd2:    bad_xfer = |HADDR[1:0];
            default: bad_xfer = 1'b1;
        endcase
    end

    assign start_xfer = addr_phase & ~bad_xfer;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (addr_phase) state_nxt = bad_xfer ? ST_ERR1 : ST_BUSY;
            end
            ST_BUSY: begin
                if (mem_ack) state_nxt = ST_IDLE;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus-facing outputs are decoded from the next state so they leave the flops already valid.
    always_comb begin
        ready_nxt = 1'b1;
        req_nxt   = 1'b0;
        resp_nxt  = 1'b0;
        case (state_nxt)
            ST_BUSY: begin
                ready_nxt = 1'b0;
                req_nxt   = 1'b1;
            end
            ST_ERR1: begin
                ready_nxt = 1'b0;
                resp_nxt  = 1'b1;
            end
            ST_ERR2: resp_nxt = 1'b1;
            default: ready_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRESP <= 1'b0;
        end else begin
            HRESP <= resp_nxt;
        end
    end
`else
    assign start_xfer = addr_phase;
    assign HRESP      = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (addr_phase) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (mem_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = 1'b1;
        req_nxt   = 1'b0;
        if (state_nxt == ST_BUSY) begin
            ready_nxt = 1'b0;
            req_nxt   = 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            HRDATA    <= '0;
        end else begin
            state     <= state_nxt;
            HREADYOUT <= ready_nxt;
            mem_req   <= req_nxt;
            // Request fields change only on a new accept, so they stay frozen while mem_req is high.
            if (start_xfer) begin
                mem_we   <= HWRITE;
                mem_addr <= HADDR[ADDR_W-1:2];
                mem_be   <= be_dec;
            end
            if ((state == ST_BUSY) && mem_ack && !mem_we) begin
                HRDATA <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_fe.sv
// Scoreboard bench for ahb_lite_slave_fe: pipelined AHB master, SDRAM core model and a monitor
// comparing every data-phase cycle against an abstract transfer model.
module tb_ahb_lite_slave_fe;
    localparam int ADDR_W = 25;

    logic              clk;
    logic              rst_n;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              hready;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic              hresp;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    assign hready = hreadyout;

    ahb_lite_slave_fe #(.ADDR_W(ADDR_W)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                is_mem;
        bit                we;
        bit                err;
        logic [ADDR_W-3:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
        int                len;
    } exp_t;

    exp_t        resp_q[$];
    int          ack_q[$];
    logic [31:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hrdata = '0;
    bit          ap_tag = 1'b0;
    bit          mon_hold = 1'b1;
    bit          dp_active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what the bus and the core should see for one address phase.
    function automatic exp_t model(input logic sel, input logic [1:0] trans, input logic wr,
                                   input logic [2:0] size, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int d, input logic [31:0] rdata);
        exp_t        e;
        int unsigned off;
        e = '{default: 0};
        e.len = 1;
        off = addr % 4;
        if (!(sel && trans >= 2)) return e;
`ifdef AHB_SLV_ERR_RESP_EN
        if (size > 2 || (size == 1 && off % 2 == 1) || (size == 2 && off != 0)) begin
            e.err = 1'b1;
            e.len = 2;
            return e;
        end
`endif
        e.is_mem = 1'b1;
        e.we     = wr;
        e.addr   = (ADDR_W-2)'((addr % (32'd1 << ADDR_W)) / 4);
        e.wdata  = wdata;
        e.rdata  = rdata;
        e.len    = d + 2;
        if (size == 0)      e.be = 4'(1 << off);
        else if (size == 1) e.be = (off >= 2) ? 4'hC : 4'h3;
        else                e.be = 4'hF;
        return e;
    endfunction

    // Waits until the current address phase is taken by the bus (HREADY high at the edge).
    task automatic wait_ap();
        int n = 0;
        forever begin
            @(negedge clk);
            if (hreadyout) break;
            if (++n > 50) begin
                check("hready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] rdata);
        exp_t e;
        e = model(sel, trans, wr, size, addr, wdata, d, rdata);
        resp_q.push_back(e);
        if (e.is_mem) begin
            ack_q.push_back(d);
            rd_q.push_back(rdata);
        end
        hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; ap_tag = 1'b1;
        wait_ap();
        hwdata = wdata;
        hsel = 1'b0; htrans = 2'b00; ap_tag = 1'b0;
        if (e.err) wait_ap();
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_q.size() == 0 && !dp_active) break;
        end
        check("drain_empty", 64'(resp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_hrdata", hrdata, 64'd0);
        check("rst_hreadyout", hreadyout, 64'd1);
        check("rst_hresp", hresp, 64'd0);
        check("rst_mem_req", mem_req, 64'd0);
        check("rst_mem_we", mem_we, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_be", mem_be, 64'd0);
    endtask

    // SDRAM core model: acks each request after its queued delay, pulses stray acks when idle.
    initial begin
        bit          serving = 1'b0;
        int          cnt = 0;
        int          d = 0;
        logic [31:0] rd = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (!serving) begin
                    serving = 1'b1;
                    cnt = 0;
                    d  = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
                    rd = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
                end
                if (cnt == d) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                    serving = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                serving = 1'b0;
                mem_ack = ($urandom_range(3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops one expectation per tagged data phase and checks every cycle of it.
    initial begin
        exp_t cur;
        int   dp_len = 0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                dp_active = 1'b0;
                continue;
            end
            if (dp_active) begin
                dp_len++;
                check("hresp", hresp, cur.err);
                check("hreadyout", hreadyout, dp_len >= cur.len);
                check("mem_req", mem_req, cur.is_mem && dp_len < cur.len);
                if (cur.is_mem && dp_len < cur.len) begin
                    check("mem_we", mem_we, cur.we);
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", mem_be, cur.be);
                    check("mem_wdata", mem_wdata, cur.wdata);
                end
                if (hreadyout) begin
                    if (cur.is_mem && !cur.we) exp_hrdata = cur.rdata;
                    check("hrdata", hrdata, exp_hrdata);
                    dp_active = 1'b0;
                end
            end else begin
                check("idle_hreadyout", hreadyout, 64'd1);
                check("idle_mem_req", mem_req, 64'd0);
                check("idle_hresp", hresp, 64'd0);
            end
            if (ap_tag && hreadyout) begin
                if (resp_q.size() > 0) begin
                    cur = resp_q.pop_front();
                    dp_active = 1'b1;
                    dp_len = 0;
                end else begin
                    check("resp_q_underflow", 64'd0, 64'd1);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_hold = 1'b0;

        // Directed cases from the test plan.
        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 32'h1122_3344);
        issue(1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0202, 32'hCAFE_F00D, 1, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 3'd2, 32'h0000_0204, 32'h0, 3, 32'h5566_7788);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) issue(1'b0, 2'b10, 1'b1, 3'd2, $urandom, $urandom, 0, 32'h0);
            else            issue(1'b1, 2'(i % 4 == 1 ? 0 : 1), 1'b0, 3'd2, $urandom, $urandom, 0, 32'h0);
        end
        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0102, 32'h0BAD_0BAD, 1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 3'd1, 32'h0000_0107, 32'h0, 0, 32'h9999_AAAA);
        drain();

        // Reset while a request is outstanding.
        mon_hold = 1'b1;
        ack_q.push_back(30);
        rd_q.push_back(32'h0);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0000_0300;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("busy_mem_req", mem_req, 64'd1);
        check("busy_hreadyout", hreadyout, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 64'd0);
        check("abort_hreadyout", hreadyout, 64'd1);
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        exp_hrdata = '0;
        @(posedge clk);
        #1;
        mon_hold = 1'b0;
        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0400, 32'hA5A5_5A5A, 1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 0, 32'h7777_0001);

        // Randomized traffic, including idle/unselected and misaligned transfers.
        for (int i = 0; i < 200; i++) begin
            int          kind;
            logic [2:0]  sz;
            kind = $urandom_range(9);
            sz = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2));
            if (kind == 0)
                issue(1'b0, 2'($urandom), 1'($urandom), sz, $urandom, $urandom, 0, 32'h0);
            else if (kind == 1)
                issue(1'b1, 2'($urandom_range(1)), 1'($urandom), sz, $urandom, $urandom, 0, 32'h0);
            else
                issue(1'b1, 2'($urandom_range(3, 2)), 1'($urandom), sz, $urandom, $urandom,
                      $urandom_range(4), $urandom);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        check("ack_q_empty", 64'(ack_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
